// File: rtl/de_rr_queue_pkg.sv
// Shared layout of the 265-bit decode-to-RR bundle. RR unpacks with these
// same offsets, so any change here must be mirrored there.
package de_rr_queue_pkg;

    localparam int BUNDLE_W = 265;
    localparam int CS_W     = 60;

    localparam int CS_HI        = 264;
    localparam int CS_REV_LSB   = 205;
    localparam int IMM_LSB      = 173;
    localparam int DISP_LSB     = 141;
    localparam int IMMSIZE_LSB  = 139;
    localparam int DISPSIZE_LSB = 137;
    localparam int SIB_BIT      = 136;
    localparam int SCALE_LSB    = 134;
    localparam int BASEREN_BIT  = 133;
    localparam int IDXREN_BIT   = 132;
    localparam int NEIP_LSB     = 100;
    localparam int EIP_LSB      = 68;
    localparam int BPTGT_LSB    = 36;
    localparam int IMM8_LSB     = 28;
    localparam int OPSIZE_LSB   = 26;
    localparam int SR1_LSB      = 23;
    localparam int SR2_LSB      = 20;
    localparam int BASE_LSB     = 17;
    localparam int IDX_LSB      = 14;
    localparam int SEGR1_LSB    = 11;
    localparam int SEGR2_LSB    = 8;
    localparam int BPTAKEN_BIT  = 7;
    localparam int INDIR_BIT    = 6;
    localparam int DFLAG_BIT    = 5;
    localparam int BRFID_LSB    = 1;
    localparam int VALID_BIT    = 0;

    typedef logic [BUNDLE_W-1:0] bundle_t;

    typedef struct packed {
        logic [CS_W-1:0] cs;
        logic [31:0]     imm;
        logic [31:0]     disp;
        logic [31:0]     neip;
        logic [31:0]     eip;
        logic [31:0]     bp_tgt;
        logic [7:0]      imm8;
        logic [1:0]      imm_size;
        logic [1:0]      disp_size;
        logic [1:0]      scale;
        logic [1:0]      op_size;
        logic [2:0]      sr1;
        logic [2:0]      sr2;
        logic [2:0]      base;
        logic [2:0]      idx;
        logic [2:0]      seg_r1;
        logic [2:0]      seg_r2;
        logic            is_sib;
        logic            base_ren;
        logic            idx_ren;
        logic            bp_taken;
        logic            indir;
        logic            dflag;
        logic [3:0]      br_fetch_id;
    } de_fields_t;

endpackage

// File: rtl/rr_bundle_pack.sv
// Combinational packer from decoder fields to the RR bundle. CS bits below the
// MSB land bit-reversed in the upper field.
module rr_bundle_pack
    import de_rr_queue_pkg::*;
(
    input  de_fields_t fields,
    output bundle_t    bundle
);

    always_comb begin
        bundle = '0;
        bundle[CS_HI] = fields.cs[CS_W-1];
        for (int k = 0; k < CS_W - 1; k++) begin
            bundle[CS_REV_LSB + k] = fields.cs[CS_W - 2 - k];
        end
        bundle[IMM_LSB      +: 32] = fields.imm;
        bundle[DISP_LSB     +: 32] = fields.disp;
        bundle[IMMSIZE_LSB  +: 2]  = fields.imm_size;
        bundle[DISPSIZE_LSB +: 2]  = fields.disp_size;
        bundle[SIB_BIT]            = fields.is_sib;
        bundle[SCALE_LSB    +: 2]  = fields.scale;
        bundle[BASEREN_BIT]        = fields.base_ren;
        bundle[IDXREN_BIT]         = fields.idx_ren;
        bundle[NEIP_LSB     +: 32] = fields.neip;
        bundle[EIP_LSB      +: 32] = fields.eip;
        bundle[BPTGT_LSB    +: 32] = fields.bp_tgt;
        bundle[IMM8_LSB     +: 8]  = fields.imm8;
        bundle[OPSIZE_LSB   +: 2]  = fields.op_size;
        bundle[SR1_LSB      +: 3]  = fields.sr1;
        bundle[SR2_LSB      +: 3]  = fields.sr2;
        bundle[BASE_LSB     +: 3]  = fields.base;
        bundle[IDX_LSB      +: 3]  = fields.idx;
        bundle[SEGR1_LSB    +: 3]  = fields.seg_r1;
        bundle[SEGR2_LSB    +: 3]  = fields.seg_r2;
        bundle[BPTAKEN_BIT]        = fields.bp_taken;
        bundle[INDIR_BIT]          = fields.indir;
        bundle[DFLAG_BIT]          = fields.dflag;
        bundle[BRFID_LSB    +: 4]  = fields.br_fetch_id;
        // Anything that gets stored is a real instruction.
        bundle[VALID_BIT]          = 1'b1;
    end

endmodule

// File: rtl/de_rr_queue.sv
// Decode-to-RR issue queue: packs decoder fields and buffers DEPTH bundles,
// presenting the head to the RR latch, which loads whenever stall is low.
module de_rr_queue
    import de_rr_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     i_v,
    input  logic [CS_W-1:0]          i_CS,
    input  logic [31:0]              i_imm,
    input  logic [31:0]              i_disp,
    input  logic [31:0]              i_nEIP,
    input  logic [31:0]              i_EIP,
    input  logic [31:0]              i_bp_tgt,
    input  logic [7:0]               i_imm8,
    input  logic [1:0]               i_immSize,
    input  logic [1:0]               i_dispSize,
    input  logic [1:0]               i_scale,
    input  logic [1:0]               i_opSize,
    input  logic [2:0]               i_sr1,
    input  logic [2:0]               i_sr2,
    input  logic [2:0]               i_base,
    input  logic [2:0]               i_idx,
    input  logic [2:0]               i_SegR1,
    input  logic [2:0]               i_SegR2,
    input  logic                     i_isSIB,
    input  logic                     i_baseRen,
    input  logic                     i_idxRen,
    input  logic                     i_bp_taken,
    input  logic                     i_indir,
    input  logic                     i_Dflag,
    input  logic [3:0]               i_brFetchId,
    output logic [BUNDLE_W-1:0]      o_bundle,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    de_fields_t fields;
    bundle_t    packed_in;

    assign fields = '{
        cs: i_CS, imm: i_imm, disp: i_disp, neip: i_nEIP, eip: i_EIP,
        bp_tgt: i_bp_tgt, imm8: i_imm8, imm_size: i_immSize,
        disp_size: i_dispSize, scale: i_scale, op_size: i_opSize,
        sr1: i_sr1, sr2: i_sr2, base: i_base, idx: i_idx,
        seg_r1: i_SegR1, seg_r2: i_SegR2, is_sib: i_isSIB,
        base_ren: i_baseRen, idx_ren: i_idxRen, bp_taken: i_bp_taken,
        indir: i_indir, dflag: i_Dflag, br_fetch_id: i_brFetchId
    };

    rr_bundle_pack u_pack (
        .fields (fields),
        .bundle (packed_in)
    );

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          nonempty;
    logic          enq;
    logic          deq;

    assign full     = (count == CW'(DEPTH));
    assign nonempty = (count != '0);
    // A full queue drops the write even when a read frees a slot this cycle.
    assign enq      = i_v & ~flush & ~full;
    assign deq      = ~stall & ~flush & nonempty;

    logic [DEPTH-1:0][BUNDLE_W-1:0] ent;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic    we;
        bundle_t q;

        assign we = enq && (tail == PW'(i));

        always_ff @(posedge clk) begin
            if (we) q <= packed_in;
        end

        assign ent[i] = q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq);
            tail  <= tail + PW'(enq);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // flush kills the valid bit combinationally so RR latches a bubble now.
    always_comb begin
        o_bundle = '0;
        if (nonempty) begin
            o_bundle            = ent[head];
            o_bundle[VALID_BIT] = ~flush;
        end
    end

    assign o_full  = full;
    assign o_count = count;

endmodule
